ex_muldiv: RTL
==============

# ex_muldiv

Iterative multiply/divide unit in the EX stage, on the read side of the ID/EX pipeline register. It consumes the latched operands (ReadData1_o / ReadData2_o) when a MULT/MULTU/DIV/DIVU instruction sits in ID/EX and computes over multiple cycles into the architectural HI/LO registers. It raises `busy` so hazard logic can stall the front end.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI/LO are `WIDTH` each; iteration count = `WIDTH`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only when idle.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `rs_val` in WIDTH: multiplicand / dividend (from ReadData1_o).
- `rt_val` in WIDTH: multiplier / divisor (from ReadData2_o).
- `mthi` in 1: write `wdata` to HI.
- `mtlo` in 1: write `wdata` to LO.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: operation in flight; drives the stall.
- `done` out 1: one-cycle pulse after HI/LO update.
- `div_by_zero` out 1: last DIV/DIVU had divisor 0; held until next accepted `start`.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States: IDLE, RUN, FIX.
- Reset value of all outputs is 0: `busy`, `done`, `div_by_zero`, `hi`, `lo`. State returns to IDLE and the counter clears.
- IDLE + `start`:
  - Latch `op`.
  - Latch operand magnitudes: absolute value for signed ops, raw value for unsigned ops.
  - Latch result sign flags.
  - Clear `div_by_zero`.
  - For a divide with `rt_val`==0: go to FIX and set `div_by_zero`. Otherwise go to RUN with counter = WIDTH-1.
- RUN, multiply: radix-2 shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first. Remainder register is WIDTH+1 bits.
- RUN: decrement the counter each cycle and go to FIX after the counter reaches 0, i.e. after WIDTH RUN cycles.
- FIX, multiply: negate the 64-bit product if operand signs differ (signed op only). {hi,lo} <= product.
- FIX, divide: negate the quotient if signs differ. The remainder takes the sign of the dividend. lo <= quotient, hi <= remainder.
- FIX, divide-by-zero: lo <= all ones, hi <= `rs_val` as latched (unmodified). No sign fix.
- FIX always goes to IDLE.
- Signed overflow: DIV 0x80000000 / -1 gives lo=0x80000000, hi=0. This falls out of the magnitude path and needs no special case.
- `mthi`/`mtlo` while IDLE with no `start` write HI/LO at the next edge. Both may be asserted together.
- `start` has priority: in the same cycle as `mthi`/`mtlo`, the moves are dropped.
- `start`, `mthi`, `mtlo` while not IDLE are ignored. The pipeline guarantees the stall.

## Timing
- `start` sampled at edge E0.
- `busy` = (state != IDLE). It is high from after E0 through the FIX cycle.
- Normal op:
  - WIDTH RUN cycles followed by 1 FIX cycle.
  - `busy` high for WIDTH+1 = 33 cycles.
  - HI/LO update at edge E0+33.
  - `done` high for the cycle after E0+33, then drops.
- Divide-by-zero:
  - 1 FIX cycle; HI/LO update at E0+1.
  - `done` high for the cycle after E0+1.
  - `div_by_zero` visible from E0+1.
- `done` and `busy` are never high in the same cycle.
- A new `start` is accepted in the same cycle `done` is high (state is IDLE).
- Reset mid-operation: next cycle is IDLE, `busy`=0, `hi`/`lo`=0. No `done` pulse. The partial result is discarded.
- HI/LO are stable throughout RUN; they change only at the FIX edge or on an idle move.

## Structure
- Shared package `mips_pkg`:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state encoding for IDLE/RUN/FIX
  - default WIDTH constant
- Single module; no sub-module. Negate/abs are inline expressions.
- The counter is $clog2(WIDTH) bits.
- The accumulator and the remainder/quotient pair share one 2*WIDTH+1 register.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; `busy` 33 cycles; `done` one cycle after the update edge.
- MULT 0xFFFFFFFD (-3) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5 / 0 -> `div_by_zero`=1, hi=5, lo=0xFFFFFFFF; `done` one cycle after the E0+1 update edge.
- Second `start` and an `mthi` issued mid-RUN -> both ignored; the first result is unchanged. `mtlo` 0x1234 while idle -> lo=0x1234 next cycle. `start` + `mthi` in the same idle cycle -> the op runs and HI gets the op result.
- `reset` asserted 10 cycles into a MULT -> next cycle `busy`=0, hi=lo=0, no `done`. A following DIVU 9/3 completes normally: lo=3, hi=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: HI/LO unit opcodes, FSM state encoding,
// and the default datapath width.
package mips_pkg;

  localparam int unsigned MD_WIDTH = 32;

  // MULT/DIV opcode: bit 1 selects divide, bit 0 selects unsigned
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Multiply/divide sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit feeding the architectural HI/LO registers.
// Radix-2 shift-add multiply (LSB first) and restoring divide (MSB first)
// over operand magnitudes, followed by one sign-fix cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, op           one-cycle request + opcode, sampled only when idle
//   rs_val, rt_val      multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata   idle-time moves into HI/LO
//   busy, done          op in flight / one-cycle completion pulse
//   div_by_zero         last divide had a zero divisor
//   hi, lo              HI/LO registers
module ex_muldiv
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH + 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             neg_q;    // product / quotient must be negated
  logic             rneg_q;   // remainder takes the dividend's sign
  logic [WIDTH-1:0] b_q;      // multiplicand or divisor magnitude
  logic [AW-1:0]    acc_q;    // product accumulator, or {remainder, quotient}

  // Operand conditioning at start
  logic             signed_c, is_div_c, rt_zero_c;
  logic [WIDTH-1:0] rs_mag_c, rt_mag_c;

  assign signed_c  = ~op[0];
  assign is_div_c  = op[1];
  assign rt_zero_c = (rt_val == '0);
  assign rs_mag_c  = (signed_c && rs_val[WIDTH-1]) ? WIDTH'(~rs_val + 1'b1) : rs_val;
  assign rt_mag_c  = (signed_c && rt_val[WIDTH-1]) ? WIDTH'(~rt_val + 1'b1) : rt_val;

  // One multiply or divide iteration on the shared accumulator
  logic [WIDTH:0]  mul_hi_c, div_rem_c;
  logic [AW-1:0]   mul_step_c, div_shift_c, div_step_c;

  always_comb begin
    mul_hi_c = acc_q[AW-1:WIDTH];
    if (acc_q[0]) mul_hi_c = acc_q[AW-1:WIDTH] + {1'b0, b_q};
    mul_step_c = {mul_hi_c, acc_q[WIDTH-1:0]} >> 1;

    div_shift_c = {acc_q[AW-2:0], 1'b0};
    div_rem_c   = div_shift_c[AW-1:WIDTH];
    div_step_c  = div_shift_c;
    if (div_rem_c >= {1'b0, b_q})
      div_step_c = {div_rem_c - {1'b0, b_q}, div_shift_c[WIDTH-1:1], 1'b1};
  end

  // Sign restoration applied in FIX
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   quot_c, rem_c;

  assign prod_c = neg_q  ? (2*WIDTH)'(~acc_q[2*WIDTH-1:0] + 1'b1) : acc_q[2*WIDTH-1:0];
  assign quot_c = neg_q  ? WIDTH'(~acc_q[WIDTH-1:0] + 1'b1)       : acc_q[WIDTH-1:0];
  assign rem_c  = rneg_q ? WIDTH'(~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (is_div_c && rt_zero_c) ? ST_FIX : ST_RUN;
      ST_RUN:  if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      b_q         <= '0;
      acc_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            is_div_q    <= is_div_c;
            div_by_zero <= is_div_c && rt_zero_c;
            cnt_q       <= CW'(WIDTH - 1);
            neg_q       <= signed_c & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            rneg_q      <= signed_c & rs_val[WIDTH-1];
            if (is_div_c) begin
              b_q   <= rt_mag_c;
              // a zero divisor keeps the raw dividend for HI
              acc_q <= rt_zero_c ? AW'(rs_val) : AW'(rs_mag_c);
            end else begin
              b_q   <= rs_mag_c;
              acc_q <= AW'(rt_mag_c);
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        ST_RUN: begin
          acc_q <= is_div_q ? div_step_c : mul_step_c;
          cnt_q <= cnt_q - 1'b1;
        end
        ST_FIX: begin
          done <= 1'b1;
          if (div_by_zero) begin
            lo <= '1;
            hi <= acc_q[WIDTH-1:0];
          end else if (is_div_q) begin
            lo <= quot_c;
            hi <= rem_c;
          end else begin
            {hi, lo} <= prod_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
